addsub_serial: RTL and testbench
================================

Name: addsub_serial

Overview:
- Parametrised, multi-cycle successor to the team's 8-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB digit first, under a start/done handshake.
- Adds a mode select and registered carry/borrow, signed-overflow and zero flags.
- Sits on datapaths where area matters more than single-cycle latency.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 2, bits processed per cycle; N = WIDTH/DIGIT cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only when busy=0
- mode  input  1  0 = add (in1+in2+cin); 1 = subtract (in1-in2-cin, cin acts as borrow-in)
- in1  input  WIDTH  operand A, sampled with start
- in2  input  WIDTH  operand B, sampled with start
- cin  input  1  carry-in (add) / borrow-in (sub), sampled with start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; result outputs are valid
- sum  output  WIDTH  result
- cout  output  1  carry-out (add) / borrow-out (sub)
- ovf  output  1  two's-complement signed overflow
- zero  output  1  sum == 0

Behaviour:
- Reset (async, any state): FSM=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, zero=0, internal registers cleared.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at edge E0:
  - Latch in1, B' = (mode ? ~in2 : in2), and mode.
  - Carry register c0 = (mode ? ~cin : cin).
  - Digit counter = 0; go to RUN.
- IDLE or DONE with start=0: go to / stay in IDLE.
- RUN, each edge:
  - {c, d} = A_digit + B'_digit + c.
  - Shift d into the result register from the MSB side; counter++.
  - On the N-th RUN edge (edge E0+N), commit results and go to DONE.
- Commit at E0+N:
  - sum = result register.
  - cout = mode ? ~c_final : c_final.
  - ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]).
  - zero = (sum == 0).
- Timing:
  - busy=1 from after E0 until after E0+N.
  - done=1 for exactly the one cycle following E0+N.
  - Latency is therefore N cycles from the start edge.
- DONE lasts one cycle; busy=0 there, so a start in that cycle is accepted (back-to-back issue).
- start while busy=1 is ignored: no re-latch, no effect on the running operation.
- sum, cout, ovf and zero change only at commit or reset; they hold the last result across IDLE and during the next RUN.
- All arithmetic is modulo 2^WIDTH; there are no sign-extension ports.
- Reset asserted mid-RUN aborts the operation; no done pulse is produced for it.

Test Plan (WIDTH=8, DIGIT=2 unless stated; N=4):
- Add: start, mode=0, in1=0x5A, in2=0x3C, cin=0 -> done exactly 4 edges after the start edge; sum=0x96, cout=0, ovf=1, zero=0; busy high for 4 cycles.
- Subtract: mode=1, in1=0x10, in2=0x20, cin=0 -> sum=0xF0, cout=1 (borrow), ovf=0, zero=0. Then in1=0x80, in2=0x01 -> sum=0x7F, cout=0, ovf=1.
- Carry-in wrap: mode=0, in1=0xFF, in2=0x00, cin=1 -> sum=0x00, cout=1, zero=1, ovf=0. Then mode=1, in1=0x05, in2=0x05, cin=1 -> sum=0xFF, cout=1, zero=0.
- Handshake: start re-pulsed with different operands on cycles 1–3 of a busy operation -> ignored, first result returned. Start held high in the DONE cycle -> second operation accepted; its done arrives 4 edges later.
- Reset: assert rst asynchronously between edges 2 and 3 of a run -> busy, done and all outputs drop to 0 immediately; no done follows. A fresh start of 0x01+0x01 -> sum=0x02 after 4 edges.
- Generics: WIDTH=16, DIGIT=4: in1=0xFFFF, in2=0x0001, mode=0, cin=0 -> sum=0x0000, cout=1, zero=1, latency 4. WIDTH=8, DIGIT=8 (N=1): 0x7F+0x01 -> sum=0x80, ovf=1, done 1 edge after start.

Source files
------------

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial adder/subtractor.
// Computes in1 + in2 + cin (mode=0) or in1 - in2 - cin (mode=1). It processes
// DIGIT bits per clock, least significant digit first, so an operation takes
// N = WIDTH/DIGIT cycles after the start edge.
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   start, mode, cin      request, add/sub select, carry/borrow-in (sampled when !busy)
//   in1, in2              WIDTH-bit operands (sampled with start)
//   busy                  operation in progress
//   done                  one-cycle pulse, result outputs valid
//   sum, cout, ovf, zero  registered result, carry/borrow-out, signed overflow, zero flag
module addsub_serial #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               mode_q, mode_d;
    logic               c_q, c_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [IDX_W-1:0]   base;
    logic [DIGIT:0]     digit_sum;
    logic [WIDTH-1:0]   res_next;

    // Bit offset of the digit handled this cycle.
    assign base = IDX_W'(32'(cnt_q) * DIGIT);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            c_q     <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            c_q     <= c_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, digit arithmetic and result commit.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        c_d      = c_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        digit_sum = {1'b0, a_q[base +: DIGIT]} + {1'b0, b_q[base +: DIGIT]}
                  + (DIGIT + 1)'(c_q);
        // Placing each digit at its own offset is equivalent to shifting
        // digits in from the MSB side, LSB digit first.
        res_next = res_q;
        res_next[base +: DIGIT] = digit_sum[DIGIT-1:0];

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Subtract as A + ~B + 1; borrow-in becomes an inverted carry-in.
                    a_d     = in1;
                    b_d     = mode ? ~in2 : in2;
                    mode_d  = mode;
                    c_d     = mode ^ cin;
                    cnt_d   = '0;
                    res_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                c_d    = digit_sum[DIGIT];
                res_d  = res_next;
                cnt_d  = cnt_q + CNT_W'(1);
                busy_d = 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    sum_d   = res_next;
                    // Borrow-out is the inverted final carry when subtracting.
                    cout_d  = mode_q ^ digit_sum[DIGIT];
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                           && (res_next[WIDTH-1] != a_q[WIDTH-1]);
                    zero_d  = (res_next == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial: 8/2 main instance, plus 16/4 and 8/8 instances.
module tb_addsub_serial;

    logic clk;
    logic rst;

    logic       start, mode, cin;
    logic [7:0] in1, in2;
    logic       busy, done, cout, ovf, zero;
    logic [7:0] sum;

    logic        s16_start, s16_mode, s16_cin;
    logic [15:0] s16_in1, s16_in2;
    logic        s16_busy, s16_done, s16_cout, s16_ovf, s16_zero;
    logic [15:0] s16_sum;

    logic       s1_start, s1_mode, s1_cin;
    logic [7:0] s1_in1, s1_in2;
    logic       s1_busy, s1_done, s1_cout, s1_ovf, s1_zero;
    logic [7:0] s1_sum;

    int n_checks;
    int n_pass;

    addsub_serial #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .in1(in1), .in2(in2),
        .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
        .zero(zero)
    );

    addsub_serial #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .start(s16_start), .mode(s16_mode), .in1(s16_in1),
        .in2(s16_in2), .cin(s16_cin), .busy(s16_busy), .done(s16_done),
        .sum(s16_sum), .cout(s16_cout), .ovf(s16_ovf), .zero(s16_zero)
    );

    addsub_serial #(.WIDTH(8), .DIGIT(8)) dut1 (
        .clk(clk), .rst(rst), .start(s1_start), .mode(s1_mode), .in1(s1_in1),
        .in2(s1_in2), .cin(s1_cin), .busy(s1_busy), .done(s1_done),
        .sum(s1_sum), .cout(s1_cout), .ovf(s1_ovf), .zero(s1_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Pulse start for one edge on the 8/2 instance; returns #1 after the start edge.
    task automatic issue(input logic m, input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        start = 1'b1; mode = m; in1 = a; in2 = b; cin = c;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called #1 after a start edge: busy for 4 cycles, done on the 4th edge.
    task automatic expect_done(input string tag, input logic [7:0] e_sum,
                               input logic e_cout, input logic e_ovf, input logic e_zero);
        check({tag, ".busy0"}, 32'(busy), 32'(1));
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            check({tag, ".busy"}, 32'(busy), 32'(1));
            check({tag, ".early_done"}, 32'(done), 32'(0));
        end
        @(posedge clk); #1;
        check({tag, ".done"}, 32'(done), 32'(1));
        check({tag, ".busy_end"}, 32'(busy), 32'(0));
        check({tag, ".sum"}, 32'(sum), 32'(e_sum));
        check({tag, ".cout"}, 32'(cout), 32'(e_cout));
        check({tag, ".ovf"}, 32'(ovf), 32'(e_ovf));
        check({tag, ".zero"}, 32'(zero), 32'(e_zero));
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst = 1'b1;
        start = 1'b0; mode = 1'b0; cin = 1'b0; in1 = '0; in2 = '0;
        s16_start = 1'b0; s16_mode = 1'b0; s16_cin = 1'b0; s16_in1 = '0; s16_in2 = '0;
        s1_start = 1'b0; s1_mode = 1'b0; s1_cin = 1'b0; s1_in1 = '0; s1_in2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", 32'(busy), 32'(0));
        check("rst.done", 32'(done), 32'(0));
        check("rst.sum", 32'(sum), 32'(0));
        check("rst.flags", 32'({cout, ovf, zero}), 32'(0));
        @(negedge clk) rst = 1'b0;

        // Basic add and subtract vectors.
        issue(1'b0, 8'h5A, 8'h3C, 1'b0);
        expect_done("add", 8'h96, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("add.done_pulse", 32'(done), 32'(0));
        check("add.hold_sum", 32'(sum), 32'(8'h96));

        issue(1'b1, 8'h10, 8'h20, 1'b0);
        expect_done("sub1", 8'hF0, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 8'h80, 8'h01, 1'b0);
        expect_done("sub2", 8'h7F, 1'b0, 1'b1, 1'b0);

        // Carry-in / borrow-in wrap.
        issue(1'b0, 8'hFF, 8'h00, 1'b1);
        expect_done("cin_add", 8'h00, 1'b1, 1'b0, 1'b1);
        issue(1'b1, 8'h05, 8'h05, 1'b1);
        expect_done("bin_sub", 8'hFF, 1'b1, 1'b0, 1'b0);

        // Starts while busy are ignored.
        issue(1'b0, 8'h01, 8'h02, 1'b0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            start = 1'b1; mode = 1'b1; in1 = 8'hAA; in2 = 8'h11; cin = 1'b1;
            @(posedge clk); #1;
            check("hs.busy", 32'(busy), 32'(1));
        end
        @(negedge clk) start = 1'b0;
        @(posedge clk); #1;
        check("hs.done", 32'(done), 32'(1));
        check("hs.sum", 32'(sum), 32'(8'h03));
        check("hs.cout", 32'(cout), 32'(0));

        // Start in the DONE cycle: back-to-back issue.
        start = 1'b1; mode = 1'b0; in1 = 8'h22; in2 = 8'h33; cin = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b.no_done", 32'(done), 32'(0));
        expect_done("b2b", 8'h55, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges 2 and 3 of a run.
        issue(1'b0, 8'h5A, 8'h3C, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst.busy", 32'(busy), 32'(0));
        check("arst.done", 32'(done), 32'(0));
        check("arst.sum", 32'(sum), 32'(0));
        check("arst.flags", 32'({cout, ovf, zero}), 32'(0));
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("arst.no_done", 32'(done), 32'(0));
        end
        issue(1'b0, 8'h01, 8'h01, 1'b0);
        expect_done("post_rst", 8'h02, 1'b0, 1'b0, 1'b0);

        // WIDTH=16, DIGIT=4: latency 4.
        @(negedge clk);
        s16_start = 1'b1; s16_mode = 1'b0; s16_in1 = 16'hFFFF; s16_in2 = 16'h0001; s16_cin = 1'b0;
        @(posedge clk);
        #1 s16_start = 1'b0;
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            check("w16.busy", 32'(s16_busy), 32'(1));
            check("w16.early_done", 32'(s16_done), 32'(0));
        end
        @(posedge clk); #1;
        check("w16.done", 32'(s16_done), 32'(1));
        check("w16.sum", 32'(s16_sum), 32'(16'h0000));
        check("w16.cout", 32'(s16_cout), 32'(1));
        check("w16.zero", 32'(s16_zero), 32'(1));
        check("w16.ovf", 32'(s16_ovf), 32'(0));

        // WIDTH=8, DIGIT=8: single-cycle operation.
        @(negedge clk);
        s1_start = 1'b1; s1_mode = 1'b0; s1_in1 = 8'h7F; s1_in2 = 8'h01; s1_cin = 1'b0;
        @(posedge clk);
        #1 s1_start = 1'b0;
        check("n1.busy", 32'(s1_busy), 32'(1));
        @(posedge clk); #1;
        check("n1.done", 32'(s1_done), 32'(1));
        check("n1.sum", 32'(s1_sum), 32'(8'h80));
        check("n1.ovf", 32'(s1_ovf), 32'(1));
        check("n1.cout", 32'(s1_cout), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
